// File: rtl/request_unit_pkg.sv
// Shared types for the request unit.
//   reqstate_t : request sequencer state (FETCH, DATA, HALTED), 2-bit encoding
//   CNT_W_DEFAULT : default width of the stall-cycle counter
package request_unit_pkg;

    localparam int unsigned CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        FETCH  = 2'b00,
        DATA   = 2'b01,
        HALTED = 2'b10
    } reqstate_t;

endpackage

// File: rtl/request_unit_if.sv
// Bundle of the control/cache-facing request unit signals.
//   ru : request unit view (hits and control decisions in, enables out)
//   tb : driver view (mirror of ru)
interface request_unit_if;

    logic MemRead;
    logic MemWrite;
    logic halt;
    logic ihit;
    logic dhit;
    logic iREN;
    logic dREN;
    logic dWEN;
    logic pc_en;
    logic halted;

    modport ru (
        input  MemRead, MemWrite, halt, ihit, dhit,
        output iREN, dREN, dWEN, pc_en, halted
    );

    modport tb (
        output MemRead, MemWrite, halt, ihit, dhit,
        input  iREN, dREN, dWEN, pc_en, halted
    );

endinterface

// File: rtl/request_unit_sat_counter.sv
// Unsigned up-counter that sticks at its maximum value instead of wrapping.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset, clears the count
//   inc_i   : increment by one this cycle (ignored at maximum)
//   clr_i   : synchronous clear, takes priority over inc_i
//   count_o : current count
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o
);

    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != MAX)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/request_unit.sv
// Memory request sequencer for the single-cycle MIPS datapath.
// Paces the datapath on ihit/dhit and drives the memory arbiter enables.
//   CLK, nRST        : clock (rising edge), asynchronous active-low reset
//   MemRead/MemWrite : current instruction loads/stores
//   halt             : current instruction is HALT
//   ihit/dhit        : instruction fetch / data access completes this cycle
//   iREN             : instruction read enable (decoded from state)
//   dREN/dWEN        : data read/write enable (registered)
//   pc_en            : PC advance strobe, one cycle per retired instruction
//   halted           : sticky halted flag (registered)
//   proto_err        : pulse when a load and store are both requested on ihit
//   stall_cnt        : saturating count of cycles spent waiting on a hit
module request_unit
    import request_unit_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic             halt,
    input  logic             ihit,
    input  logic             dhit,
    output logic             iREN,
    output logic             dREN,
    output logic             dWEN,
    output logic             pc_en,
    output logic             halted,
    output logic             proto_err,
    output logic [CNT_W-1:0] stall_cnt
);

    reqstate_t state_q, state_d;
    logic      dren_q, dren_d;
    logic      dwen_q, dwen_d;
    logic      halted_q, halted_d;
    logic      iren_c;
    logic      pc_en_c;
    logic      proto_err_c;
    logic      stall_inc_c;

    // Next state, data enables and per-cycle strobes.
    always_comb begin
        state_d     = state_q;
        dren_d      = dren_q;
        dwen_d      = dwen_q;
        halted_d    = halted_q;
        iren_c      = 1'b0;
        pc_en_c     = 1'b0;
        proto_err_c = 1'b0;
        stall_inc_c = 1'b0;

        case (state_q)
            FETCH: begin
                iren_c = 1'b1;
                dren_d = 1'b0;
                dwen_d = 1'b0;
                if (ihit) begin
                    if (halt) begin
                        state_d  = HALTED;
                        halted_d = 1'b1;
                    end else if (MemRead || MemWrite) begin
                        state_d     = DATA;
                        dren_d      = MemRead;
                        // A conflicting request is treated as a load.
                        dwen_d      = MemWrite && !MemRead;
                        proto_err_c = MemRead && MemWrite;
                    end else begin
                        pc_en_c = 1'b1;
                    end
                end else begin
                    stall_inc_c = 1'b1;
                end
            end
            DATA: begin
                // Data side owns the shared port; control inputs were latched on entry.
                if (dhit) begin
                    pc_en_c = 1'b1;
                    dren_d  = 1'b0;
                    dwen_d  = 1'b0;
                    state_d = FETCH;
                end else begin
                    stall_inc_c = 1'b1;
                end
            end
            HALTED: begin
                halted_d = 1'b1;
            end
            default: begin
                state_d = FETCH;
                dren_d  = 1'b0;
                dwen_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= FETCH;
            dren_q   <= 1'b0;
            dwen_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dren_q   <= dren_d;
            dwen_q   <= dwen_d;
            halted_q <= halted_d;
        end
    end

    // Stall counter is cleared only by reset.
    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk_i   (CLK),
        .rst_ni  (nRST),
        .inc_i   (stall_inc_c),
        .clr_i   (1'b0),
        .count_o (stall_cnt)
    );

    assign iREN      = iren_c;
    assign dREN      = dren_q;
    assign dWEN      = dwen_q;
    assign pc_en     = pc_en_c;
    assign halted    = halted_q;
    assign proto_err = proto_err_c;

endmodule

// File: tb/tb_request_unit.sv
// Directed bench for request_unit: a CNT_W=16 instance driven through the
// interface and a CNT_W=4 instance sharing the same inputs for saturation.
module tb_request_unit;

    logic        CLK;
    logic        nRST;
    logic        proto_err;
    logic [15:0] stall_cnt;
    logic        iren4, dren4, dwen4, pc_en4, halted4, proto_err4;
    logic [3:0]  stall4;

    int checks   = 0;
    int failures = 0;

    request_unit_if ifc ();

    request_unit #(.CNT_W(16)) u_dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .MemRead   (ifc.MemRead),
        .MemWrite  (ifc.MemWrite),
        .halt      (ifc.halt),
        .ihit      (ifc.ihit),
        .dhit      (ifc.dhit),
        .iREN      (ifc.iREN),
        .dREN      (ifc.dREN),
        .dWEN      (ifc.dWEN),
        .pc_en     (ifc.pc_en),
        .halted    (ifc.halted),
        .proto_err (proto_err),
        .stall_cnt (stall_cnt)
    );

    request_unit #(.CNT_W(4)) u_dut4 (
        .CLK       (CLK),
        .nRST      (nRST),
        .MemRead   (ifc.MemRead),
        .MemWrite  (ifc.MemWrite),
        .halt      (ifc.halt),
        .ihit      (ifc.ihit),
        .dhit      (ifc.dhit),
        .iREN      (iren4),
        .dREN      (dren4),
        .dWEN      (dwen4),
        .pc_en     (pc_en4),
        .halted    (halted4),
        .proto_err (proto_err4),
        .stall_cnt (stall4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc;
        @(posedge CLK);
        #2;
    endtask

    initial begin
        nRST         = 1'b1;
        ifc.MemRead  = 1'b0;
        ifc.MemWrite = 1'b0;
        ifc.halt     = 1'b0;
        ifc.ihit     = 1'b0;
        ifc.dhit     = 1'b0;
        #1 nRST = 1'b0;
        #2;

        // Reset state
        chk("rst_iREN",  32'(ifc.iREN),   32'd1);
        chk("rst_dREN",  32'(ifc.dREN),   32'd0);
        chk("rst_dWEN",  32'(ifc.dWEN),   32'd0);
        chk("rst_halted", 32'(ifc.halted), 32'd0);
        chk("rst_pc_en", 32'(ifc.pc_en),  32'd0);
        chk("rst_proto", 32'(proto_err),  32'd0);
        chk("rst_stall", 32'(stall_cnt),  32'd0);
        chk("rst_stall4", 32'(stall4),    32'd0);

        // 1. Back-to-back non-memory instructions retire every cycle
        nRST     = 1'b1;
        ifc.ihit = 1'b1;
        #1;
        chk("nm_pc_en0", 32'(ifc.pc_en), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("nm_pc_en", 32'(ifc.pc_en), 32'd1);
            chk("nm_iREN",  32'(ifc.iREN),  32'd1);
            chk("nm_dREN",  32'(ifc.dREN),  32'd0);
            chk("nm_dWEN",  32'(ifc.dWEN),  32'd0);
        end
        chk("nm_stall", 32'(stall_cnt), 32'd0);

        // 2. Load with three wait cycles
        ifc.MemRead = 1'b1;
        #1;
        chk("ld_issue_pc_en", 32'(ifc.pc_en), 32'd0);
        chk("ld_issue_proto", 32'(proto_err), 32'd0);
        cyc();
        ifc.MemRead = 1'b0;
        ifc.ihit    = 1'b0;
        #1;
        chk("ld_dREN",  32'(ifc.dREN),  32'd1);
        chk("ld_iREN",  32'(ifc.iREN),  32'd0);
        chk("ld_pc_en", 32'(ifc.pc_en), 32'd0);
        cyc();
        cyc();
        cyc();
        ifc.dhit = 1'b1;
        #1;
        chk("ld_dhit_pc_en", 32'(ifc.pc_en), 32'd1);
        chk("ld_dhit_dREN",  32'(ifc.dREN),  32'd1);
        chk("ld_stall",      32'(stall_cnt), 32'd3);
        cyc();
        ifc.dhit = 1'b0;
        ifc.ihit = 1'b1;
        #1;
        chk("ld_done_dREN",  32'(ifc.dREN),  32'd0);
        chk("ld_done_iREN",  32'(ifc.iREN),  32'd1);
        chk("ld_done_stall", 32'(stall_cnt), 32'd3);

        // 3a. Store with ihit asserted while waiting for dhit
        ifc.MemWrite = 1'b1;
        #1;
        chk("st_issue_pc_en", 32'(ifc.pc_en), 32'd0);
        chk("st_issue_proto", 32'(proto_err), 32'd0);
        cyc();
        ifc.MemWrite = 1'b0;
        #1;
        chk("st_dWEN",  32'(ifc.dWEN),  32'd1);
        chk("st_dREN",  32'(ifc.dREN),  32'd0);
        chk("st_iREN",  32'(ifc.iREN),  32'd0);
        chk("st_ihit_ignored", 32'(ifc.pc_en), 32'd0);
        cyc();
        #1;
        chk("st_dWEN_held", 32'(ifc.dWEN), 32'd1);
        chk("st_iREN_held", 32'(ifc.iREN), 32'd0);
        cyc();
        ifc.dhit = 1'b1;
        #1;
        chk("st_dhit_pc_en", 32'(ifc.pc_en), 32'd1);
        chk("st_stall",      32'(stall_cnt), 32'd5);
        cyc();
        ifc.dhit = 1'b0;
        #1;
        chk("st_done_dWEN", 32'(ifc.dWEN), 32'd0);
        chk("st_done_iREN", 32'(ifc.iREN), 32'd1);

        // 3b. Load and store both requested: read wins, error pulse
        ifc.MemRead  = 1'b1;
        ifc.MemWrite = 1'b1;
        #1;
        chk("both_proto",  32'(proto_err),  32'd1);
        chk("both_pc_en",  32'(ifc.pc_en),  32'd0);
        cyc();
        ifc.MemRead  = 1'b0;
        ifc.MemWrite = 1'b0;
        ifc.dhit     = 1'b1;
        #1;
        chk("both_proto_gone", 32'(proto_err), 32'd0);
        chk("both_dREN",  32'(ifc.dREN),  32'd1);
        chk("both_dWEN",  32'(ifc.dWEN),  32'd0);
        chk("both_pc_en_dhit", 32'(ifc.pc_en), 32'd1);
        cyc();
        ifc.dhit = 1'b0;
        #1;
        chk("both_stall", 32'(stall_cnt), 32'd5);

        // 5. Asynchronous reset in the middle of a load
        ifc.MemRead = 1'b1;
        #1;
        cyc();
        ifc.MemRead = 1'b0;
        ifc.ihit    = 1'b0;
        #1;
        chk("ar_pre_dREN", 32'(ifc.dREN), 32'd1);
        #2 nRST = 1'b0;
        #1;
        chk("ar_dREN",   32'(ifc.dREN), 32'd0);
        chk("ar_iREN",   32'(ifc.iREN), 32'd1);
        chk("ar_stall",  32'(stall_cnt), 32'd0);
        nRST     = 1'b1;
        ifc.ihit = 1'b1;
        #1;
        chk("ar_resume_pc_en", 32'(ifc.pc_en), 32'd1);
        chk("ar_resume_iREN",  32'(ifc.iREN),  32'd1);
        cyc();
        #1;
        chk("ar_resume2_pc_en", 32'(ifc.pc_en), 32'd1);

        // 4. Halt is terminal and freezes everything
        ifc.halt = 1'b1;
        #1;
        chk("h_issue_pc_en",  32'(ifc.pc_en),  32'd0);
        chk("h_issue_halted", 32'(ifc.halted), 32'd0);
        cyc();
        ifc.halt = 1'b0;
        ifc.dhit = 1'b1;
        #1;
        chk("h_halted", 32'(ifc.halted), 32'd1);
        chk("h_iREN",   32'(ifc.iREN),   32'd0);
        chk("h_pc_en",  32'(ifc.pc_en),  32'd0);
        chk("h_dREN",   32'(ifc.dREN),   32'd0);
        ifc.MemRead = 1'b1;
        cyc();
        ifc.MemRead = 1'b0;
        ifc.ihit    = 1'b0;
        ifc.dhit    = 1'b0;
        #1;
        chk("h2_halted", 32'(ifc.halted), 32'd1);
        chk("h2_dREN",   32'(ifc.dREN),   32'd0);
        cyc();
        cyc();
        cyc();
        chk("h_stall_frozen", 32'(stall_cnt), 32'd0);
        chk("h3_pc_en",  32'(ifc.pc_en), 32'd0);
        chk("h3_halted", 32'(ifc.halted), 32'd1);

        // 6. Stall counter saturation (4-bit instance) vs. 16-bit instance
        nRST = 1'b0;
        #1;
        chk("sat_rst_halted", 32'(ifc.halted), 32'd0);
        chk("sat_rst_stall4", 32'(stall4),     32'd0);
        nRST = 1'b1;
        for (int i = 0; i < 14; i++) cyc();
        chk("sat_stall4_14", 32'(stall4), 32'd14);
        cyc();
        chk("sat_stall4_15", 32'(stall4), 32'd15);
        cyc();
        chk("sat_stall4_16", 32'(stall4),    32'd15);
        chk("sat_stall_16",  32'(stall_cnt), 32'd16);
        for (int i = 0; i < 4; i++) cyc();
        chk("sat_stall4_20", 32'(stall4),    32'd15);
        chk("sat_stall_20",  32'(stall_cnt), 32'd20);
        chk("sat_iREN4",     32'(iren4),     32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
